// File: rtl/ram_readback_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_readback_if
// Description : Bus bundle between the readback engine and its neighbours.
//               The bundle groups two things: the synchronous read port of
//               the result RAM, and the valid/ready output word stream.
//               master : readback engine. It drives ram_re/ram_adr and the
//                        out_* stream, and it receives ram_dout and out_ready.
//               slave  : RAM plus consumer side. It drives ram_dout and
//                        out_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_readback_if #(
    parameter int ADR_W  = 3,
    parameter int DATA_W = 8
);
    // RAM read port
    logic              ram_re;
    logic [ADR_W-1:0]  ram_adr;
    logic [DATA_W-1:0] ram_dout;

    // Output word stream
    logic [DATA_W-1:0] out_data;
    logic [ADR_W-1:0]  out_adr;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output ram_re, ram_adr, out_data, out_adr, out_valid,
        input  ram_dout, out_ready
    );

    modport slave (
        input  ram_re, ram_adr, out_data, out_adr, out_valid,
        output ram_dout, out_ready
    );
endinterface
`default_nettype wire

// File: rtl/ram_readback.sv
`default_nettype none
// ============================================================================
// Module      : ram_readback
// Description : Walks an inclusive, wrap-around address range of the result
//               RAM. It issues one synchronous read per word and presents
//               each word on a valid/ready stream.
//   clk        : system clock, rising edge
//   rst        : asynchronous reset, active low
//   start      : one-cycle pulse. It begins a readback only when idle.
//   start_adr  : first address. It is sampled on the accepted start.
//   end_adr    : last address, inclusive. It is sampled on the accepted start.
//   bus        : ram_readback_if.master. It carries the RAM read port
//                (ram_re, ram_adr, ram_dout) and the output stream
//                (out_data, out_adr, out_valid, out_ready).
//   busy       : high from the cycle after an accepted start until done
//   done       : one-cycle pulse after the last word is accepted
//   checksum   : only present when RDBK_CHECKSUM_EN is defined. It is the
//                modulo-2^DATA_W sum of the words accepted in this readback.
// Build option: RDBK_CHECKSUM_EN adds the checksum output and its adder.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_readback #(
    parameter int ADR_W      = 3,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1    // 1 or 2
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               start,
    input  wire [ADR_W-1:0]   start_adr,
    input  wire [ADR_W-1:0]   end_adr,
    ram_readback_if.master    bus,
    output logic              busy,
    output logic              done
`ifdef RDBK_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_OUT  = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    // The wait counter counts up from 0. Its terminal value marks the cycle
    // in which the RAM data is valid.
    localparam logic [1:0] c_wait_last = 2'(RD_LATENCY - 1);

    state_t            r_state;
    logic [1:0]        r_wait_cnt;
    logic [ADR_W-1:0]  r_cur_adr;
    logic [ADR_W-1:0]  r_end_adr;
    logic              r_ram_re;
    logic [ADR_W-1:0]  r_ram_adr;
    logic [DATA_W-1:0] r_out_data;
    logic [ADR_W-1:0]  r_out_adr;
    logic              r_out_valid;
    logic              r_busy;
    logic              r_done;
`ifdef RDBK_CHECKSUM_EN
    logic [DATA_W-1:0] r_checksum;
`endif

    // The address increment wraps naturally at 2^ADR_W. Because of the wrap,
    // a range with end_adr < start_adr passes through the top address to 0.
    logic [ADR_W-1:0]  w_next_adr;
    assign w_next_adr = r_cur_adr + ADR_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wait_cnt  <= 2'd0;
            r_cur_adr   <= '0;
            r_end_adr   <= '0;
            r_ram_re    <= 1'b0;
            r_ram_adr   <= '0;
            r_out_data  <= '0;
            r_out_adr   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef RDBK_CHECKSUM_EN
            r_checksum  <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur_adr  <= start_adr;
                        r_end_adr  <= end_adr;
                        // Raise the read request together with the state
                        // change, so that ram_re is already high in the
                        // first REQ cycle.
                        r_ram_re   <= 1'b1;
                        r_ram_adr  <= start_adr;
                        r_busy     <= 1'b1;
                        r_state    <= S_REQ;
`ifdef RDBK_CHECKSUM_EN
                        r_checksum <= '0;
`endif
                    end
                end

                S_REQ: begin
                    r_ram_re   <= 1'b0;
                    r_wait_cnt <= 2'd0;
                    r_state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_wait_cnt == c_wait_last) begin
                        r_out_data  <= bus.ram_dout;
                        r_out_adr   <= r_cur_adr;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 2'd1;
                    end
                end

                S_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
`ifdef RDBK_CHECKSUM_EN
                        r_checksum  <= r_checksum + r_out_data;
`endif
                        if (r_cur_adr == r_end_adr) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_FIN;
                        end else begin
                            // Move straight to the next request. This keeps
                            // the word period at RD_LATENCY + 2 cycles.
                            r_cur_adr <= w_next_adr;
                            r_ram_adr <= w_next_adr;
                            r_ram_re  <= 1'b1;
                            r_state   <= S_REQ;
                        end
                    end
                end

                S_FIN: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ram_re    = r_ram_re;
    assign bus.ram_adr   = r_ram_adr;
    assign bus.out_data  = r_out_data;
    assign bus.out_adr   = r_out_adr;
    assign bus.out_valid = r_out_valid;
    assign busy          = r_busy;
    assign done          = r_done;
`ifdef RDBK_CHECKSUM_EN
    assign checksum      = r_checksum;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_readback.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_ram_readback
// Description : Directed testbench for ram_readback.
//               dut1 reads a RAM model with a latency of 1 cycle.
//               dut2 reads a RAM model with a latency of 2 cycles.
//               In both models, RAM word i holds 8'h11*i.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_readback;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, start2;
    logic [2:0] start_adr, end_adr, start_adr2, end_adr2;
    logic       busy, done, busy2, done2;
`ifdef RDBK_CHECKSUM_EN
    logic [7:0] checksum1, checksum2;
`endif

    ram_readback_if #(.ADR_W(3), .DATA_W(8)) rb1 ();
    ram_readback_if #(.ADR_W(3), .DATA_W(8)) rb2 ();

    ram_readback #(.ADR_W(3), .DATA_W(8), .RD_LATENCY(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_adr (start_adr),
        .end_adr   (end_adr),
        .bus       (rb1),
        .busy      (busy),
        .done      (done)
`ifdef RDBK_CHECKSUM_EN
        ,
        .checksum  (checksum1)
`endif
    );

    ram_readback #(.ADR_W(3), .DATA_W(8), .RD_LATENCY(2)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .start     (start2),
        .start_adr (start_adr2),
        .end_adr   (end_adr2),
        .bus       (rb2),
        .busy      (busy2),
        .done      (done2)
`ifdef RDBK_CHECKSUM_EN
        ,
        .checksum  (checksum2)
`endif
    );

    // RAM models
    logic [7:0] mem [0:7];
    logic [7:0] r2_stage;
    initial begin
        for (int i = 0; i < 8; i++) mem[i] = 8'(i * 17);
        rb1.ram_dout = 8'h00;
        rb2.ram_dout = 8'h00;
        r2_stage     = 8'h00;
    end

    always @(posedge clk) if (rb1.ram_re) rb1.ram_dout <= mem[rb1.ram_adr];

    always @(posedge clk) begin
        if (rb2.ram_re) r2_stage <= mem[rb2.ram_adr];
        rb2.ram_dout <= r2_stage;
    end

    // Cycle counter and handshake / request logging, sampled at the negedge
    int         cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0] adr_q[$];
    logic [7:0] dat_q[$];
    logic [2:0] re_adr_q[$];
    int         done_cnt = 0;
    logic [7:0] dat2_q[$];
    int         cyc2_q[$];
    int         done2_cnt = 0;

    always @(negedge clk) begin
        if (rb1.out_valid && rb1.out_ready) begin
            adr_q.push_back(rb1.out_adr);
            dat_q.push_back(rb1.out_data);
        end
        if (rb1.ram_re) re_adr_q.push_back(rb1.ram_adr);
        if (done) done_cnt++;
        if (rb2.out_valid && rb2.out_ready) begin
            dat2_q.push_back(rb2.out_data);
            cyc2_q.push_back(cyc);
        end
        if (done2) done2_cnt++;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        adr_q.delete();
        dat_q.delete();
        re_adr_q.delete();
        done_cnt = 0;
    endtask

    task automatic pulse_start(input logic [2:0] s, input logic [2:0] e);
        @(posedge clk); #1;
        start     = 1'b1;
        start_adr = s;
        end_adr   = e;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (rb1.out_valid) break;
            if (n >= 50) begin
                check("valid_timeout", 32'(rb1.out_valid), 32'd1);
                break;
            end
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (n >= 100) begin
                check("done_timeout", 32'(done), 32'd1);
                break;
            end
        end
    endtask

    logic [2:0] exp_adr2 [4];
    logic [7:0] exp_dat2 [4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        exp_adr2 = '{3'd6, 3'd7, 3'd0, 3'd1};
        exp_dat2 = '{8'h66, 8'h77, 8'h00, 8'h11};

        rst = 1'b0;
        start = 1'b0; start_adr = 3'd0; end_adr = 3'd0;
        start2 = 1'b0; start_adr2 = 3'd0; end_adr2 = 3'd0;
        rb1.out_ready = 1'b1;
        rb2.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk); #1;
        check("rst_outs", 32'({rb1.ram_re, rb1.ram_adr, rb1.out_data, rb1.out_adr,
                               rb1.out_valid, busy, done}), 32'd0);
        @(negedge clk); rst = 1'b1;

        // T1: range 0..3, consumer always ready
        clear_log();
        pulse_start(3'd0, 3'd3);
        wait_valid(n);
        check("t1_latency", 32'(n), 32'd3);
        check("t1_busy_mid", 32'(busy), 32'd1);
        wait_done();
        repeat (3) @(posedge clk); #1;
        check("t1_words", 32'(adr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_adr%0d", i), 32'(adr_q[i]), 32'(i));
            check($sformatf("t1_dat%0d", i), 32'(dat_q[i]), 32'(8'(i * 17)));
        end
        check("t1_done_cnt", 32'(done_cnt), 32'd1);
        check("t1_busy_after", 32'(busy), 32'd0);
`ifdef RDBK_CHECKSUM_EN
        check("t1_checksum", 32'(checksum1), 32'h66);
`endif

        // T2: range 6..1 wraps through 7 -> 0
        clear_log();
        pulse_start(3'd6, 3'd1);
        wait_done();
        repeat (3) @(posedge clk); #1;
        check("t2_words", 32'(adr_q.size()), 32'd4);
        check("t2_reqs", 32'(re_adr_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_adr%0d", i), 32'(adr_q[i]), 32'(exp_adr2[i]));
            check($sformatf("t2_dat%0d", i), 32'(dat_q[i]), 32'(exp_dat2[i]));
            check($sformatf("t2_ramadr%0d", i), 32'(re_adr_q[i]), 32'(exp_adr2[i]));
        end

        // T3: single word, consumer stalls
        clear_log();
        rb1.out_ready = 1'b0;
        pulse_start(3'd5, 3'd5);
        wait_valid(n);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t3_hold_dat%0d", i), 32'(rb1.out_data), 32'h55);
            check($sformatf("t3_hold_adr%0d", i), 32'(rb1.out_adr), 32'd5);
            check($sformatf("t3_hold_vld%0d", i), 32'(rb1.out_valid), 32'd1);
            @(negedge clk);
        end
        check("t3_no_done_in_stall", 32'(done_cnt), 32'd0);
        @(posedge clk); #1;
        rb1.out_ready = 1'b1;
        wait_done();
        repeat (3) @(posedge clk); #1;
        check("t3_words", 32'(adr_q.size()), 32'd1);
        check("t3_dat", 32'(dat_q[0]), 32'h55);
        check("t3_done_cnt", 32'(done_cnt), 32'd1);

        // T4: start pulses while busy and during FIN are ignored
        clear_log();
        pulse_start(3'd0, 3'd2);
        repeat (2) @(posedge clk); #1;
        start = 1'b1; start_adr = 3'd4; end_adr = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        start = 1'b1; start_adr = 3'd4; end_adr = 3'd4;   // FIN cycle
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("t4_words", 32'(adr_q.size()), 32'd3);
        check("t4_reqs", 32'(re_adr_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t4_adr%0d", i), 32'(adr_q[i]), 32'(i));
            check($sformatf("t4_dat%0d", i), 32'(dat_q[i]), 32'(8'(i * 17)));
        end
        check("t4_done_cnt", 32'(done_cnt), 32'd1);
        check("t4_busy", 32'(busy), 32'd0);

        // T5: asynchronous reset while in WAIT
        clear_log();
        pulse_start(3'd2, 3'd3);           // REQ cycle now
        @(posedge clk);                    // enter WAIT
        #3 rst = 1'b0;
        #1;
        check("t5_rst_outs", 32'({rb1.ram_re, rb1.ram_adr, rb1.out_data, rb1.out_adr,
                                  rb1.out_valid, busy, done}), 32'd0);
`ifdef RDBK_CHECKSUM_EN
        check("t5_rst_checksum", 32'(checksum1), 32'd0);
`endif
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        clear_log();
        repeat (10) @(posedge clk); #1;
        check("t5_no_req", 32'(re_adr_q.size()), 32'd0);
        check("t5_no_done", 32'(done_cnt), 32'd0);
        check("t5_idle_busy", 32'(busy), 32'd0);
        clear_log();
        pulse_start(3'd4, 3'd4);
        wait_done();
        repeat (3) @(posedge clk); #1;
        check("t5_words", 32'(adr_q.size()), 32'd1);
        check("t5_adr", 32'(adr_q[0]), 32'd4);
        check("t5_dat", 32'(dat_q[0]), 32'h44);

        // T6: RD_LATENCY=2 instance, range 0..1
        @(posedge clk); #1;
        start2 = 1'b1; start_adr2 = 3'd0; end_adr2 = 3'd1;
        @(posedge clk); #1;
        start2 = 1'b0;
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (rb2.out_valid) break;
        end
        check("t6_latency", 32'(n), 32'd4);
        n = 0;
        while (!done2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t6_done_seen", 32'(done2), 32'd1);
        repeat (3) @(posedge clk); #1;
        check("t6_words", 32'(dat2_q.size()), 32'd2);
        check("t6_dat0", 32'(dat2_q[0]), 32'h00);
        check("t6_dat1", 32'(dat2_q[1]), 32'h11);
        check("t6_spacing", 32'(cyc2_q[1] - cyc2_q[0]), 32'd4);
        check("t6_done_cnt", 32'(done2_cnt), 32'd1);
`ifdef RDBK_CHECKSUM_EN
        check("t6_checksum", 32'(checksum2), 32'h11);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
